// File: rtl/load_scoreboard_if.sv
// Bundles the EXE-stage decode inputs, the load response strobe and the scoreboard status
// outputs. The pipeline side (master) drives instructions and responses; the scoreboard is the slave.
interface load_scoreboard_if #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic [31:0]   instruction_EXE;
  logic          valid_EXE;
  logic          resp_valid;
  logic          stall_EXE;
  logic          issue_fire;
  logic [4:0]    wb_rd;
  logic          wb_valid;
  logic [CW-1:0] pending_count;
  logic          full;
  logic          empty;
  logic          underflow_err;

  modport master (
    output instruction_EXE, valid_EXE, resp_valid,
    input  stall_EXE, issue_fire, wb_rd, wb_valid, pending_count, full, empty, underflow_err
  );

  modport slave (
    input  instruction_EXE, valid_EXE, resp_valid,
    output stall_EXE, issue_fire, wb_rd, wb_valid, pending_count, full, empty, underflow_err
  );
endinterface

// File: rtl/load_scoreboard.sv
// In-order scoreboard of loads in flight between EXE and data memory: raises load-use and
// capacity stalls, and supplies the destination register of the oldest load for write-back.
module load_scoreboard #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  load_scoreboard_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_STORE  = 5'b01000,
    OP_BRANCH = 5'b11000,
    OP_OP     = 5'b01100,
    OP_IMM    = 5'b00100,
    OP_JALR   = 5'b11001,
    OP_LUI    = 5'b01101,
    OP_AUIPC  = 5'b00101,
    OP_JAL    = 5'b11011,
    OP_SYSTEM = 5'b11100
  } op5_e;

  logic [4:0] op5, rd, rs1, rs2;
  logic       uses_rs1, uses_rs2, is_load;
  logic       unused_instr_bits;

  assign op5 = bus.instruction_EXE[6:2];
  assign rd  = bus.instruction_EXE[11:7];
  assign rs1 = bus.instruction_EXE[19:15];
  assign rs2 = bus.instruction_EXE[24:20];
  assign unused_instr_bits = ^{bus.instruction_EXE[31:25], bus.instruction_EXE[14:12],
                               bus.instruction_EXE[1:0]};

  assign uses_rs1 = op5 inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_IMM, OP_JALR, OP_SYSTEM};
  assign uses_rs2 = op5 inside {OP_STORE, OP_BRANCH, OP_OP};
  assign is_load  = (op5 == OP_LOAD);

  logic [4:0]       rd_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             underflow_q, underflow_d;

  logic match_a, match_b, hit_a, hit_b, struct_stall;
  logic empty, full, push, pop, stall;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Only registered entries are searched, so a same-cycle response cannot release the stall.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rd_q[i] != 5'd0)) begin
        if (rs1 == rd_q[i]) match_a = 1'b1;
        if (rs2 == rd_q[i]) match_b = 1'b1;
      end
    end
  end

  assign hit_a        = bus.valid_EXE && uses_rs1 && (rs1 != 5'd0) && match_a;
  assign hit_b        = bus.valid_EXE && uses_rs2 && (rs2 != 5'd0) && match_b;
  assign struct_stall = bus.valid_EXE && is_load && full;
  assign stall        = hit_a || hit_b || struct_stall;

  assign push = bus.valid_EXE && is_load && !stall;
  assign pop  = bus.resp_valid && !empty;

  always_comb begin
    vld_d       = vld_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    underflow_d = underflow_q || (bus.resp_valid && empty);
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the rd storage is not reset; its contents are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (push) rd_q[tail_q] <= rd;
  end

  assign bus.stall_EXE     = stall;
  assign bus.issue_fire    = push;
  assign bus.wb_rd         = empty ? 5'd0 : rd_q[head_q];
  assign bus.wb_valid      = pop;
  assign bus.pending_count = count_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: stimulus queues hand-computed per-cycle expectations and
// expected write-back registers; a negedge monitor pops and compares them against the DUT.
module tb_load_scoreboard;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_scoreboard_if #(.DEPTH(DEPTH)) bus ();
  load_scoreboard #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    int cyc;
    int stall, fire, wbv, cnt, full, empty, uf, wbrd;
  } exp_t;

  exp_t exp_q[$];
  int   wb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input int exp);
    if (exp < 0) return;
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  // Drives one cycle of stimulus and queues the expected outputs for that cycle (-1 = don't care).
  task automatic step(input logic r, input logic v, input logic [31:0] instr, input logic resp,
                      input int stall, input int fire, input int wbv, input int cnt,
                      input int full, input int empty, input int uf, input int wbrd);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst                 = r;
    bus.valid_EXE       = v;
    bus.instruction_EXE = instr;
    bus.resp_valid      = resp;
    e = '{cyc, stall, fire, wbv, cnt, full, empty, uf, wbrd};
    exp_q.push_back(e);
    if (wbv == 1) wb_q.push_back(wbrd);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_EXE",     e.cyc, 32'(bus.stall_EXE),     e.stall);
      check("issue_fire",    e.cyc, 32'(bus.issue_fire),    e.fire);
      check("wb_valid",      e.cyc, 32'(bus.wb_valid),      e.wbv);
      check("pending_count", e.cyc, 32'(bus.pending_count), e.cnt);
      check("full",          e.cyc, 32'(bus.full),          e.full);
      check("empty",         e.cyc, 32'(bus.empty),         e.empty);
      check("underflow_err", e.cyc, 32'(bus.underflow_err), e.uf);
      check("wb_rd",         e.cyc, 32'(bus.wb_rd),         e.wbrd);
      if (bus.wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL wb_unexpected cycle %0d: got wb_rd %0d expected no write-back",
                   e.cyc, bus.wb_rd);
        end else begin
          check("wb_order", e.cyc, 32'(bus.wb_rd), wb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    bus.valid_EXE       = 1'b1;
    bus.instruction_EXE = NOP;
    bus.resp_valid      = 1'b0;
    repeat (2) @(posedge clk);

    //   rst v  instr             resp stall fire wbv cnt full empty uf wbrd
    // Reset state, idle nop
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   0,  0);
    // Load-use hazard on x5 (c2 is a bubble and must not stall)
    step(0, 1, 32'h0000_A283,   0,   0,   1,   0,  0,  0,   1,   0,  0);
    step(0, 1, add(6, 5, 2),    0,   1,   0,   0,  1,  0,   0,   0,  5);
    step(0, 0, add(6, 5, 2),    0,   0,   0,   0,  1,  0,   0,   0,  5);
    step(0, 1, add(6, 5, 2),    1,   1,   0,   1,  1,  0,   0,   0,  5);
    step(0, 1, add(6, 5, 2),    0,   0,   0,   0,  0,  0,   1,   0,  0);
    // rs2-only dependence through a store
    step(0, 1, lw(7, 0),        0,   0,   1,   0,  0,  0,   1,   0,  0);
    step(0, 1, sw(7, 3),        0,   1,   0,   0,  1,  0,   0,   0,  7);
    step(0, 1, sw(7, 3),        1,   1,   0,   1,  1,  0,   0,   0,  7);
    step(0, 1, sw(7, 3),        0,   0,   0,   0,  0,  0,   1,   0,  0);
    // Load to x0 never causes a hazard but still occupies a slot
    step(0, 1, lw(0, 2),        0,   0,   1,   0,  0,  0,   1,   0,  0);
    step(0, 1, add(1, 0, 0),    0,   0,   0,   0,  1,  0,   0,   0,  0);
    step(0, 1, NOP,             1,   0,   0,   1,  1,  0,   0,   0,  0);
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   0,  0);
    // Capacity: fill, blocked third load (also during a response), then accepted
    step(0, 1, lw(8, 1),        0,   0,   1,   0,  0,  0,   1,   0,  0);
    step(0, 1, lw(9, 1),        0,   0,   1,   0,  1,  0,   0,   0,  8);
    step(0, 1, lw(10, 1),       0,   1,   0,   0,  2,  1,   0,   0,  8);
    step(0, 1, lw(10, 1),       1,   1,   0,   1,  2,  1,   0,   0,  8);
    step(0, 1, lw(10, 1),       0,   0,   1,   0,  1,  0,   0,   0,  9);
    step(0, 1, NOP,             0,   0,   0,   0,  2,  1,   0,   0,  9);
    step(0, 1, NOP,             1,   0,   0,   1,  2,  1,   0,   0,  9);
    step(0, 1, NOP,             1,   0,   0,   1,  1,  0,   0,   0, 10);
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   0,  0);
    // Simultaneous push and pop
    step(0, 1, lw(12, 1),       0,   0,   1,   0,  0,  0,   1,   0,  0);
    step(0, 1, lw(11, 1),       1,   0,   1,   1,  1,  0,   0,   0, 12);
    step(0, 1, NOP,             0,   0,   0,   0,  1,  0,   0,   0, 11);
    step(0, 1, NOP,             1,   0,   0,   1,  1,  0,   0,   0, 11);
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   0,  0);
    // Underflow is sticky
    step(0, 1, NOP,             1,   0,   0,   0,  0,  0,   1,   0,  0);
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   1,  0);
    // Reset mid-operation discards entries and clears underflow
    step(0, 1, lw(13, 1),       0,   0,   1,   0,  0,  0,   1,   1,  0);
    step(0, 1, lw(14, 1),       0,   0,   1,   0,  1,  0,   0,   1, 13);
    step(1, 1, add(15, 13, 14), 0,   1,   0,   0,  2,  1,   0,   1, 13);
    step(0, 1, add(15, 13, 14), 0,   0,   0,   0,  0,  0,   1,   0,  0);
    step(0, 1, NOP,             1,   0,   0,   0,  0,  0,   1,   0,  0);
    step(0, 1, NOP,             0,   0,   0,   0,  0,  0,   1,   1,  0);

    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    check("exp_drain", cyc, 32'(exp_q.size()), 0);
    check("wb_drain",  cyc, 32'(wb_q.size()),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Producer-side companion to the EXE/MWB forwarding logic in the three-stage pipeline.
- Tracks destination registers of loads issued from EXE whose data has not yet returned from data memory. Responses return in order.
- Asserts stall_EXE when the EXE instruction reads a register with a load still in flight, or when no tracking slot is free for a new load.
- Supplies the write-back rd of the oldest outstanding load to the register-file write port.

Parameters:
DEPTH, 2, maximum outstanding loads (power of two, 2..8)
CW, $clog2(DEPTH+1), width of pending_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
instruction_EXE  input  32  instruction currently in EXE
valid_EXE  input  1  instruction_EXE is a real instruction (0 = bubble)
resp_valid  input  1  one load response returns this cycle (oldest entry)
stall_EXE  output  1  hold EXE, inject bubble into MWB
issue_fire  output  1  EXE load accepted into scoreboard this cycle
wb_rd  output  5  rd of oldest outstanding load; 0 when empty
wb_valid  output  1  resp_valid && !empty (write-back enable for load data)
pending_count  output  CW  number of outstanding loads
full  output  1  pending_count == DEPTH
empty  output  1  pending_count == 0
underflow_err  output  1  sticky: resp_valid seen while empty

Behaviour:
- Reset (rst=1 at clk edge):
  - all entries invalid; head/tail pointers 0; pending_count=0; underflow_err=0.
  - outputs then read: stall_EXE=0 (unless the EXE instruction is a stalling load), full=0, empty=1, wb_rd=0.
  - Reset mid-operation discards all outstanding entries; responses arriving afterward are treated as underflow.
- Decode from instruction_EXE:
  - op5=[6:2], rd=[11:7], rs1=[19:15], rs2=[24:20].
  - Opcode values: LOAD 00000, STORE 01000, BRANCH 11000, OP 01100, OP-IMM 00100, JALR 11001, LUI 01101, AUIPC 00101, JAL 11011, SYSTEM 11100.
  - uses_rs1 = op5 in {LOAD, STORE, BRANCH, OP, OP-IMM, JALR, SYSTEM}.
  - uses_rs2 = op5 in {STORE, BRANCH, OP}.
  - is_load = (op5==LOAD).
- Hazard detection (combinational, registered entries only):
  - hit_a = valid_EXE && uses_rs1 && rs1!=0 && (rs1 matches any valid entry's rd).
  - hit_b = the same test for rs2.
  - Entries with rd==0 never match.
  - A response in the current cycle does NOT clear the hazard that cycle. The stall releases the cycle after the matching pop.
- Structural stall: struct = valid_EXE && is_load && full. A simultaneous resp_valid does not relieve full in the same cycle.
- stall_EXE = hit_a || hit_b || struct.
- Issue: issue_fire = valid_EXE && is_load && !stall_EXE.
  - Push rd (including rd==0) at tail; tail increments modulo DEPTH.
  - rd==0 is pushed so responses stay matched in order.
- Pop: when resp_valid && !empty, invalidate the head entry; head increments modulo DEPTH.
  - wb_rd shows the head rd combinationally; wb_valid=1 the same cycle.
- Simultaneous push and pop: both occur; pending_count unchanged.
  - On full, a push cannot coincide with a pop, because struct blocks it.
- resp_valid while empty: no state change except underflow_err<=1, held until rst.
- Latency:
  - Load issued in cycle N → entry visible to hazard check in N+1.
  - Response popped in cycle M → dependent instruction released in M+1.
- pending_count, full and empty derive from registered state only.

Test Plan:
- Reset then idle, instruction_EXE=32'h00000013 (nop), valid_EXE=1 → stall_EXE=0, empty=1, pending_count=0, wb_rd=0.
- Load-use hazard:
  - Cycle 0: lw x5,0(x1) (32'h0000A283) → issue_fire=1.
  - Cycle 1: add x6,x5,x2 → stall_EXE=1.
  - Cycle 3: resp_valid=1 → wb_valid=1, wb_rd=5, stall_EXE still 1.
  - Cycle 4: stall_EXE=0, empty=1.
- rs2-only and x0 cases:
  - Load to x7 outstanding; sw x7,0(x3) → stall=1.
  - Load to x0 outstanding; add x1,x0,x0 → stall=0; its response still pops with wb_rd=0.
- Capacity, DEPTH=2:
  - Issue loads to x8 and x9 → full=1.
  - Third load lw x10 → stall_EXE=1, issue_fire=0, including the cycle resp_valid=1 arrives.
  - Next cycle: issue_fire=1, pending_count=2.
- Simultaneous push/pop: one load outstanding; issue lw x11 while resp_valid=1 → pending_count stays 1, wb_rd = old rd, then 11 after the next response.
- Underflow and reset:
  - resp_valid=1 while empty → underflow_err=1, pending_count=0.
  - Two loads outstanding, then rst=1 for one cycle → empty=1, underflow_err=0, dependent instruction not stalled.
